// File: rtl/loadable_down_timer_pkg.sv
// Shared definitions for the loadable down-timer: state encoding and default width.
// The load/value conventions match the loadable up-counter on the same tile.
package down_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/loadable_down_timer.sv
// Loadable down-timer with start/busy/done handshake and one-cycle terminal-count pulse.
// Define AUTO_RELOAD_EN to make RUN reload from the last loaded value instead of stopping.
module loadable_down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] c_in,
    input  logic             start,
    input  logic             stop,
    input  logic             ack,
    output logic [WIDTH-1:0] c_out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_q;
    logic             tc_nxt;
    logic [WIDTH-1:0] ld_val;
    logic             at_one;
    logic [WIDTH-1:0] reload_val;
    logic             reload_ok;

    // A load in the same cycle takes effect before any start decision.
    assign ld_val = load ? c_in : cnt;
    assign at_one = (cnt == WIDTH'(1));

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= c_in;
        end
    end

    assign reload_val = reload_q;
    assign reload_ok  = (reload_q != '0);
`else
    assign reload_val = '0;
    assign reload_ok  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            tc_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tc_q  <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (ld_val != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (load) begin
                    if (c_in == '0) begin
                        state_nxt = ST_DONE;
                    end
                end else if (ena && at_one && !reload_ok) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Priority inside RUN is stop, then load, then the enabled decrement.
    always_comb begin
        cnt_nxt = cnt;
        tc_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = ld_val;
                tc_nxt  = start && (ld_val == '0);
            end
            ST_RUN: begin
                if (!stop) begin
                    if (load) begin
                        cnt_nxt = c_in;
                        tc_nxt  = (c_in == '0);
                    end else if (ena) begin
                        if (at_one) begin
                            cnt_nxt = reload_ok ? reload_val : '0;
                            tc_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt - WIDTH'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                cnt_nxt = ld_val;
            end
            default: cnt_nxt = cnt;
        endcase
    end

    assign c_out = cnt;
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);
    assign tc    = tc_q;

endmodule

// File: tb/tb_loadable_down_timer.sv
// Self-checking bench for loadable_down_timer: directed vector table plus randomized
// traffic compared against a behavioural model; follows AUTO_RELOAD_EN when defined.
module tb_loadable_down_timer;

    localparam int W = 4;

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, ena, load, start, stop, ack;
    logic [W-1:0] c_in;
    logic [W-1:0] c_out;
    logic         busy, done, tc;

    int n_checks = 0;
    int n_fail   = 0;

    loadable_down_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .load  (load),
        .c_in  (c_in),
        .start (start),
        .stop  (stop),
        .ack   (ack),
        .c_out (c_out),
        .busy  (busy),
        .done  (done),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n, ena, load;
        logic [W-1:0] c_in;
        logic         start, stop, ack;
        logic [W-1:0] e_cnt;
        logic         e_busy, e_done, e_tc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic l, input logic [W-1:0] ci,
                       input logic s, input logic sp, input logic a,
                       input logic [W-1:0] ec, input logic eb, input logic ed, input logic et);
        vec_t v;
        v.rst_n = r; v.ena = e; v.load = l; v.c_in = ci;
        v.start = s; v.stop = sp; v.ack = a;
        v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = et;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ec, input int eb, input int ed, input int et);
        check({tag, " c_out"}, int'(c_out), ec);
        check({tag, " busy"},  int'(busy),  eb);
        check({tag, " done"},  int'(done),  ed);
        check({tag, " tc"},    int'(tc),    et);
    endtask

    // Drive between edges, then sample just after the rising edge.
    task automatic step(input logic r, input logic e, input logic l, input logic [W-1:0] ci,
                        input logic s, input logic sp, input logic a);
        @(negedge clk);
        rst_n = r; ena = e; load = l; c_in = ci; start = s; stop = sp; ack = a;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: count plus two flags describing the phase of the timer.
    int  m_count;
    int  m_reload;
    bit  m_running, m_finished, m_tc;

    task automatic model_edge(input bit r, input bit e, input bit l, input int ci,
                              input bit s, input bit sp, input bit a);
        if (!r) begin
            m_count = 0; m_reload = 0; m_running = 0; m_finished = 0; m_tc = 0;
            return;
        end
        m_tc = 0;
        if (!m_running && !m_finished) begin
            if (l) m_count = ci;
            if (s) begin
                if (m_count != 0) m_running = 1;
                else begin m_finished = 1; m_tc = 1; end
            end
        end else if (m_running) begin
            if (sp) begin
                m_running = 0;
            end else if (l) begin
                m_count = ci;
                if (m_count == 0) begin m_running = 0; m_finished = 1; m_tc = 1; end
            end else if (e) begin
                m_count = (m_count + (1 << W) - 1) % (1 << W);
                if (m_count == 0) begin
                    m_tc = 1;
                    if (AUTO && m_reload != 0) m_count = m_reload;
                    else begin m_running = 0; m_finished = 1; end
                end
            end
        end else begin
            if (l) m_count = ci;
            if (a) m_finished = 0;
        end
        if (l) m_reload = ci;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; load = 1'b0; c_in = '0;
        start = 1'b0; stop = 1'b0; ack = 1'b0;

        step(0, 0, 0, 0, 0, 0, 0);
        check_outs("reset", 0, 0, 0, 0);

`ifndef AUTO_RELOAD_EN
        // basic countdown 3,2,1,0 then ack
        add(0,0,0,0,0,0,0, 0,0,0,0);
        add(1,0,1,3,0,0,0, 3,0,0,0);
        add(1,1,0,0,1,0,0, 3,1,0,0);
        add(1,1,0,0,0,0,0, 2,1,0,0);
        add(1,1,0,0,0,0,0, 1,1,0,0);
        add(1,1,0,0,0,0,0, 0,0,1,1);
        add(1,1,0,0,0,0,0, 0,0,1,0);
        add(1,0,0,0,0,0,1, 0,0,0,0);
        // start with zero, then ack+start in DONE
        add(0,0,0,0,0,0,0, 0,0,0,0);
        add(1,0,0,0,1,0,0, 0,0,1,1);
        add(1,0,0,0,0,0,0, 0,0,1,0);
        add(1,0,0,0,1,0,1, 0,0,0,0);
        // enable gating and stop
        add(1,0,1,5,0,0,0, 5,0,0,0);
        add(1,1,0,0,1,0,0, 5,1,0,0);
        add(1,1,0,0,0,0,0, 4,1,0,0);
        add(1,0,0,0,0,0,0, 4,1,0,0);
        add(1,1,0,0,0,0,0, 3,1,0,0);
        add(1,1,0,0,0,1,0, 3,0,0,0);
        add(1,1,0,0,0,0,0, 3,0,0,0);
        // priority: reload in RUN, stop beats load, load+start with zero
        add(1,0,0,0,1,0,0, 3,1,0,0);
        add(1,1,0,0,0,0,0, 2,1,0,0);
        add(1,1,1,7,0,0,0, 7,1,0,0);
        add(1,1,1,9,0,1,0, 7,0,0,0);
        add(1,0,1,0,1,0,0, 0,0,1,1);
        add(1,0,0,0,0,0,1, 0,0,0,0);
        // reset mid-RUN overrides everything
        add(1,0,1,9,0,0,0, 9,0,0,0);
        add(1,1,0,0,1,0,0, 9,1,0,0);
        add(1,1,0,0,0,0,0, 8,1,0,0);
        add(1,1,0,0,0,0,0, 7,1,0,0);
        add(1,1,0,0,0,0,0, 6,1,0,0);
        add(0,1,1,5,1,0,0, 0,0,0,0);
        // load of zero in RUN, load and start in DONE, hold with ena low
        add(1,0,1,2,0,0,0, 2,0,0,0);
        add(1,0,0,0,1,0,0, 2,1,0,0);
        add(1,1,1,0,0,0,0, 0,0,1,1);
        add(1,0,1,6,0,0,0, 6,0,1,0);
        add(1,0,0,0,1,0,0, 6,0,1,0);
        add(1,0,0,0,0,0,1, 6,0,0,0);
        add(1,0,0,0,1,0,0, 6,1,0,0);
        add(1,0,0,0,0,0,0, 6,1,0,0);
        add(1,0,0,0,1,0,0, 6,1,0,0);
        add(1,0,0,0,0,1,0, 6,0,0,0);
        // shortest run: load 1
        add(1,0,1,1,0,0,0, 1,0,0,0);
        add(1,1,0,0,1,0,0, 1,1,0,0);
        add(1,1,0,0,0,0,0, 0,0,1,1);
        add(1,0,0,0,0,0,1, 0,0,0,0);
`else
        // periodic reload 2,1,2,1 with tc each period, then stop
        add(0,0,0,0,0,0,0, 0,0,0,0);
        add(1,0,1,2,0,0,0, 2,0,0,0);
        add(1,1,0,0,1,0,0, 2,1,0,0);
        add(1,1,0,0,0,0,0, 1,1,0,0);
        add(1,1,0,0,0,0,0, 2,1,0,1);
        add(1,1,0,0,0,0,0, 1,1,0,0);
        add(1,0,0,0,0,0,0, 1,1,0,0);
        add(1,1,0,0,0,0,0, 2,1,0,1);
        add(1,1,0,0,0,1,0, 2,0,0,0);
        // reload of zero still ends in DONE
        add(1,0,1,1,0,0,0, 1,0,0,0);
        add(1,0,0,0,1,0,0, 1,1,0,0);
        add(1,1,0,0,0,0,0, 1,1,0,1);
        add(1,1,1,0,0,0,0, 0,0,1,1);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].ena, vecs[i].load, vecs[i].c_in,
                 vecs[i].start, vecs[i].stop, vecs[i].ack);
            check_outs($sformatf("vec%0d", i), int'(vecs[i].e_cnt), int'(vecs[i].e_busy),
                       int'(vecs[i].e_done), int'(vecs[i].e_tc));
        end

        model_edge(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_outs("rand reset", m_count, int'(m_running), int'(m_finished), int'(m_tc));

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, e, l, s, sp, a;
            int ci;
            r  = ($urandom_range(0, 99) != 0);
            e  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 15) == 0);
            a  = ($urandom_range(0, 3) == 0);
            ci = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
            model_edge(r, e, l, ci, s, sp, a);
            step(r, e, l, W'(ci), s, sp, a);
            check_outs($sformatf("rand%0d", cyc), m_count, int'(m_running),
                       int'(m_finished), int'(m_tc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
